// File: rtl/hm_req_sched_pkg.sv
// ---------------------------------------------------------------------------
// hm_req_sched_pkg
// Shared definitions for the host-memory read request scheduler: the state
// encoding, which is also exported on stat_state, and the default values of
// the scheduler parameters.
// ---------------------------------------------------------------------------
package hm_req_sched_pkg;

    typedef enum logic [2:0] {
        HM_SCHED_STATE_IDLE    = 3'd0,
        HM_SCHED_STATE_ISSUE   = 3'd1,
        HM_SCHED_STATE_WAIT_TX = 3'd2,
        HM_SCHED_STATE_DRAIN   = 3'd3,
        HM_SCHED_STATE_DONE    = 3'd4
    } hm_sched_state_e;

    localparam logic [63:0] HM_SCHED_DEFAULT_STRIDE          = 64'd4096;
    localparam int          HM_SCHED_DEFAULT_MAX_OUTSTANDING = 4;
    localparam int          HM_SCHED_DEFAULT_MAX_RETRY       = 3;
    localparam int          HM_SCHED_DEFAULT_CNT_W           = 32;

    // The credit counter is 4 bits wide, so MAX_OUTSTANDING may be 1..15.
    localparam int          HM_SCHED_CREDIT_W                = 4;

endpackage

// File: rtl/hm_sched_credit.sv
// ---------------------------------------------------------------------------
// hm_sched_credit
// Counts the requests that have been accepted by the transmit engine but
// not yet completed by the receive side.
//   trn_clk, trn_reset_n : clock, asynchronous active-low reset
//   inc                  : a request was accepted (tx_end)
//   dec                  : a request completed (cpl_done)
//   count                : requests currently in flight
//   credit_ok            : another request may be issued
//   underflow            : completion arrived with nothing in flight (pulse)
// ---------------------------------------------------------------------------
module hm_sched_credit
    import hm_req_sched_pkg::*;
#(
    parameter int MAX_OUTSTANDING = HM_SCHED_DEFAULT_MAX_OUTSTANDING
) (
    input  logic                         trn_clk,
    input  logic                         trn_reset_n,
    input  logic                         inc,
    input  logic                         dec,
    output logic [HM_SCHED_CREDIT_W-1:0] count,
    output logic                         credit_ok,
    output logic                         underflow
);

    localparam logic [HM_SCHED_CREDIT_W-1:0] MAX_CNT = HM_SCHED_CREDIT_W'(MAX_OUTSTANDING);

    // A simultaneous inc and dec cancel; a dec at zero is dropped and flagged
    // so that late completions after an abort never wrap the counter.
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples the same pre-edge values regardless of block order.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign credit_ok = (count < MAX_CNT);
    assign underflow = dec && !inc && (count == '0);

endmodule

// File: rtl/hm_req_sched.sv
// ---------------------------------------------------------------------------
// hm_req_sched
// Walks a contiguous host address range as fixed-size Memory Read requests
// to the TLP transmit engine, limiting requests in flight, retrying timed-out
// requests and reporting completion/error to the control layer.
//   trn_clk, trn_reset_n : clock, asynchronous active-low reset
//   start, abort, pause  : run control (start is a pulse, others levels)
//   base_addr, req_count : run description, latched on start in IDLE
//   cpl_done             : one pulse per fully completed request
//   tx_start, hm_addr    : request to the transmit engine
//   tx_end, timeout      : transmit engine accepted / gave up the request
//   busy, done, err      : status (err sticky until next start)
//   cpl_underflow        : sticky, completion with nothing outstanding
//   stat_req, stat_retry : saturating counters of accepts / timeouts
//   stat_state           : current state encoding
// ---------------------------------------------------------------------------
module hm_req_sched
    import hm_req_sched_pkg::*;
#(
    parameter logic [63:0] STRIDE          = HM_SCHED_DEFAULT_STRIDE,
    parameter int          MAX_OUTSTANDING = HM_SCHED_DEFAULT_MAX_OUTSTANDING,
    parameter int          MAX_RETRY       = HM_SCHED_DEFAULT_MAX_RETRY,
    parameter int          CNT_W           = HM_SCHED_DEFAULT_CNT_W
) (
    input  logic             trn_clk,
    input  logic             trn_reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [63:0]      base_addr,
    input  logic [CNT_W-1:0] req_count,
    input  logic             cpl_done,
    output logic             tx_start,
    output logic [63:0]      hm_addr,
    input  logic             tx_end,
    input  logic             timeout,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cpl_underflow,
    output logic [CNT_W-1:0] stat_req,
    output logic [CNT_W-1:0] stat_retry,
    output logic [2:0]       stat_state
);

    localparam logic [HM_SCHED_CREDIT_W-1:0] RETRY_LAST = HM_SCHED_CREDIT_W'(MAX_RETRY - 1);

    hm_sched_state_e              state;
    logic [63:0]                  cur_addr;
    logic [CNT_W-1:0]             remaining;
    logic [HM_SCHED_CREDIT_W-1:0] retry_cnt;
    logic [HM_SCHED_CREDIT_W-1:0] outstanding;
    logic                         credit_ok;
    logic                         credit_underflow;
    logic                         accept;

    // tx_end wins over a coincident timeout.
    assign accept = (state == HM_SCHED_STATE_WAIT_TX) && tx_end;

    hm_sched_credit #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .trn_clk     (trn_clk),
        .trn_reset_n (trn_reset_n),
        .inc         (accept),
        .dec         (cpl_done),
        .count       (outstanding),
        .credit_ok   (credit_ok),
        .underflow   (credit_underflow)
    );

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state         <= HM_SCHED_STATE_IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            retry_cnt     <= '0;
            tx_start      <= 1'b0;
            hm_addr       <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            cpl_underflow <= 1'b0;
            stat_req      <= '0;
            stat_retry    <= '0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;

            case (state)
                HM_SCHED_STATE_IDLE: begin
                    if (start) begin
                        cur_addr      <= base_addr;
                        remaining     <= req_count;
                        retry_cnt     <= '0;
                        err           <= 1'b0;
                        cpl_underflow <= 1'b0;
                        stat_req      <= '0;
                        stat_retry    <= '0;
                        if (req_count == '0) begin
                            state <= HM_SCHED_STATE_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= HM_SCHED_STATE_ISSUE;
                        end
                    end
                end

                HM_SCHED_STATE_ISSUE: begin
                    if (abort) begin
                        state <= HM_SCHED_STATE_IDLE;
                    end else if (!pause && credit_ok) begin
                        tx_start <= 1'b1;
                        hm_addr  <= cur_addr;
                        state    <= HM_SCHED_STATE_WAIT_TX;
                    end
                end

                // abort is only acted on once the transmit engine has
                // resolved the request in flight.
                HM_SCHED_STATE_WAIT_TX: begin
                    if (tx_end) begin
                        cur_addr  <= cur_addr + STRIDE;
                        remaining <= remaining - CNT_W'(1);
                        retry_cnt <= '0;
                        stat_req  <= (stat_req == '1) ? stat_req : stat_req + CNT_W'(1);
                        if (abort)
                            state <= HM_SCHED_STATE_IDLE;
                        else if (remaining == CNT_W'(1))
                            state <= HM_SCHED_STATE_DRAIN;
                        else
                            state <= HM_SCHED_STATE_ISSUE;
                    end else if (timeout) begin
                        stat_retry <= (stat_retry == '1) ? stat_retry : stat_retry + CNT_W'(1);
                        if (retry_cnt == RETRY_LAST) begin
                            err   <= 1'b1;
                            state <= abort ? HM_SCHED_STATE_IDLE : HM_SCHED_STATE_DRAIN;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= abort ? HM_SCHED_STATE_IDLE : HM_SCHED_STATE_ISSUE;
                        end
                    end
                end

                HM_SCHED_STATE_DRAIN: begin
                    if (outstanding == '0) begin
                        state <= HM_SCHED_STATE_DONE;
                        done  <= 1'b1;
                    end else if (abort) begin
                        state <= HM_SCHED_STATE_IDLE;
                    end
                end

                HM_SCHED_STATE_DONE: begin
                    state <= HM_SCHED_STATE_IDLE;
                end

                default: begin
                    state <= HM_SCHED_STATE_IDLE;
                end
            endcase

            // An underflow in the same cycle as a start must stay visible,
            // so it is applied after the start-time clear.
            if (credit_underflow)
                cpl_underflow <= 1'b1;
        end
    end

    assign busy       = (state != HM_SCHED_STATE_IDLE);
    assign stat_state = state;

endmodule

// File: tb/tb_hm_req_sched.sv
module tb_hm_req_sched;

    localparam int CNT_W = 32;

    localparam logic [63:0] S_IDLE  = 64'd0;
    localparam logic [63:0] S_ISSUE = 64'd1;
    localparam logic [63:0] S_WAIT  = 64'd2;
    localparam logic [63:0] S_DRAIN = 64'd3;
    localparam logic [63:0] S_DONE  = 64'd4;

    logic             trn_clk;
    logic             trn_reset_n;
    logic             start;
    logic             abort;
    logic             pause;
    logic [63:0]      base_addr;
    logic [CNT_W-1:0] req_count;
    logic             cpl_done;
    logic             tx_start;
    logic [63:0]      hm_addr;
    logic             tx_end;
    logic             timeout;
    logic             busy;
    logic             done;
    logic             err;
    logic             cpl_underflow;
    logic [CNT_W-1:0] stat_req;
    logic [CNT_W-1:0] stat_retry;
    logic [2:0]       stat_state;

    int vectors     = 0;
    int miscompares = 0;

    hm_req_sched dut (
        .trn_clk       (trn_clk),
        .trn_reset_n   (trn_reset_n),
        .start         (start),
        .abort         (abort),
        .pause         (pause),
        .base_addr     (base_addr),
        .req_count     (req_count),
        .cpl_done      (cpl_done),
        .tx_start      (tx_start),
        .hm_addr       (hm_addr),
        .tx_end        (tx_end),
        .timeout       (timeout),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .cpl_underflow (cpl_underflow),
        .stat_req      (stat_req),
        .stat_retry    (stat_retry),
        .stat_state    (stat_state)
    );

    initial trn_clk = 1'b0;
    always #5 trn_clk = ~trn_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic step();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Wait (bounded) for a tx_start pulse.
    task automatic wait_tx(input string tag, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen, 1'b1);
    endtask

    // Count tx_start pulses over n cycles.
    task automatic count_tx(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (tx_start === 1'b1) pulses++;
        end
    endtask

    task automatic pulse_tx_end();
        tx_end = 1'b1;
        step();
        tx_end = 1'b0;
    endtask

    task automatic pulse_timeout();
        timeout = 1'b1;
        step();
        timeout = 1'b0;
    endtask

    task automatic pulse_cpl();
        cpl_done = 1'b1;
        step();
        cpl_done = 1'b0;
    endtask

    task automatic start_run(input logic [63:0] base, input logic [CNT_W-1:0] cnt);
        base_addr = base;
        req_count = cnt;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    int n;

    initial begin
        trn_reset_n = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        pause       = 1'b0;
        base_addr   = '0;
        req_count   = '0;
        cpl_done    = 1'b0;
        tx_end      = 1'b0;
        timeout     = 1'b0;

        // Reset state
        #2;
        check("rst_state",    stat_state, S_IDLE);
        check("rst_busy",     busy, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_hm_addr",  hm_addr, 0);
        check("rst_done",     done, 0);
        check("rst_err",      err, 0);
        #10;
        trn_reset_n = 1'b1;
        step();

        // 1: three requests; pause holds issue; completions drained afterwards
        pause = 1'b1;
        start_run(64'h0000_0000_1000_0000, 3);
        check("t1_busy", busy, 1);
        count_tx(3, n);
        check("t1_paused_tx", n, 0);
        check("t1_paused_state", stat_state, S_ISSUE);
        pause = 1'b0;
        wait_tx("t1_tx0", 2);
        check("t1_addr0", hm_addr, 64'h0000_0000_1000_0000);
        pulse_tx_end();
        wait_tx("t1_tx1", 2);
        check("t1_addr1", hm_addr, 64'h0000_0000_1000_1000);
        pulse_tx_end();
        wait_tx("t1_tx2", 2);
        check("t1_addr2", hm_addr, 64'h0000_0000_1000_2000);
        pulse_tx_end();
        check("t1_drain", stat_state, S_DRAIN);
        check("t1_stat_req", stat_req, 3);
        for (int k = 0; k < 3; k++) begin
            step_n(4);
            pulse_cpl();
            check("t1_no_done_yet", done, 0);
        end
        step();
        check("t1_done", done, 1);
        check("t1_state_done", stat_state, S_DONE);
        step();
        check("t1_done_pulse", done, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_stat_retry", stat_retry, 0);

        // 2: credit limit of 4, then abort from ISSUE and late completions
        start_run(64'h0000_0000_4000_0000, 6);
        for (int k = 0; k < 4; k++) begin
            wait_tx("t2_tx", 2);
            pulse_tx_end();
        end
        count_tx(6, n);
        check("t2_stalled_tx", n, 0);
        check("t2_busy", busy, 1);
        check("t2_state", stat_state, S_ISSUE);
        pulse_cpl();
        wait_tx("t2_tx5", 2);
        check("t2_addr5", hm_addr, 64'h0000_0000_4000_4000);
        pulse_tx_end();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t2_abort_idle", stat_state, S_IDLE);
        check("t2_stat_req", stat_req, 5);
        check("t2_outstanding", dut.u_credit.count, 4);
        for (int k = 0; k < 4; k++) pulse_cpl();
        check("t2_drained", dut.u_credit.count, 0);
        check("t2_no_underflow", cpl_underflow, 0);

        // 3: retry exhaustion
        start_run(64'h0000_0001_0000_0000, 2);
        for (int k = 0; k < 3; k++) begin
            wait_tx("t3_tx", 2);
            check("t3_addr", hm_addr, 64'h0000_0001_0000_0000);
            pulse_timeout();
            if (k < 2) check("t3_retry_state", stat_state, S_ISSUE);
        end
        check("t3_drain", stat_state, S_DRAIN);
        check("t3_err", err, 1);
        check("t3_stat_retry", stat_retry, 3);
        step();
        check("t3_done", done, 1);
        check("t3_stat_req", stat_req, 0);
        step();
        check("t3_idle", stat_state, S_IDLE);
        check("t3_err_sticky", err, 1);

        // 4: address wrap; tx_end with cpl_done in the same cycle
        start_run(64'hFFFF_FFFF_FFFF_F000, 2);
        check("t4_err_cleared", err, 0);
        wait_tx("t4_tx0", 2);
        check("t4_addr0", hm_addr, 64'hFFFF_FFFF_FFFF_F000);
        pulse_tx_end();
        wait_tx("t4_tx1", 2);
        check("t4_addr1", hm_addr, 64'h0);
        tx_end   = 1'b1;
        cpl_done = 1'b1;
        step();
        tx_end   = 1'b0;
        cpl_done = 1'b0;
        check("t4_net_unchanged", dut.u_credit.count, 1);
        check("t4_drain", stat_state, S_DRAIN);
        check("t4_no_underflow", cpl_underflow, 0);
        pulse_cpl();
        step();
        check("t4_done", done, 1);
        check("t4_stat_req", stat_req, 2);
        step();

        // 5: abort deferred in WAIT_TX, then completion underflow
        start_run(64'h0000_0000_0000_2000, 4);
        wait_tx("t5_tx0", 2);
        abort = 1'b1;
        step_n(2);
        check("t5_abort_deferred", stat_state, S_WAIT);
        pulse_tx_end();
        abort = 1'b0;
        check("t5_idle", stat_state, S_IDLE);
        check("t5_busy", busy, 0);
        check("t5_outstanding", dut.u_credit.count, 1);
        check("t5_stat_req", stat_req, 1);
        count_tx(4, n);
        check("t5_no_more_tx", n, 0);
        pulse_cpl();
        check("t5_out_zero", dut.u_credit.count, 0);
        check("t5_no_underflow", cpl_underflow, 0);
        pulse_cpl();
        check("t5_underflow", cpl_underflow, 1);
        check("t5_out_stays0", dut.u_credit.count, 0);

        // 6: asynchronous reset mid-run, then a zero-length run
        start_run(64'h0000_0000_0000_3000, 2);
        check("t6_underflow_cleared", cpl_underflow, 0);
        wait_tx("t6_tx0", 2);
        pulse_tx_end();
        wait_tx("t6_tx1", 2);
        #3;
        trn_reset_n = 1'b0;
        #1;
        check("t6_rst_state",    stat_state, S_IDLE);
        check("t6_rst_busy",     busy, 0);
        check("t6_rst_hm_addr",  hm_addr, 0);
        check("t6_rst_stat_req", stat_req, 0);
        check("t6_rst_out",      dut.u_credit.count, 0);
        #2;
        trn_reset_n = 1'b1;
        step();
        start_run(64'h0000_0000_0000_5000, 0);
        check("t6_zero_done",  done, 1);
        check("t6_zero_state", stat_state, S_DONE);
        check("t6_zero_no_tx", tx_start, 0);
        step();
        check("t6_zero_idle",  stat_state, S_IDLE);
        check("t6_zero_pulse", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
